// File: rtl/issue_scheduler_pkg.sv
// Shared types and constants for the in-order issue scheduler.
// Defines the decoded instruction format, the FU selector and the FSM encoding.
package issue_scheduler_pkg;

  localparam int NUM_REGS  = 32;
  localparam int REG_W     = $clog2(NUM_REGS);
  localparam int PAYLOAD_W = 32;
  localparam int PERF_W    = 32;

  typedef enum logic [1:0] {
    FU_ALU = 2'd0,
    FU_LSU = 2'd1,
    FU_BR  = 2'd2
  } fu_t;

  typedef struct packed {
    logic [PAYLOAD_W-1:0] payload;
    logic [REG_W-1:0]     rs1;
    logic [REG_W-1:0]     rs2;
    logic [REG_W-1:0]     rd;
    logic                 rd_we;
    fu_t                  fu;
  } decoded_instr_t;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_HELD  = 1'b1
  } state_t;

  // x0 is hardwired, so it never produces or waits on a result
  function automatic logic reg_nonzero(input logic [REG_W-1:0] r);
    return r != '0;
  endfunction

endpackage

// File: rtl/issue_scheduler_if.sv
// Queue-side, FU-side and writeback signals of the issue scheduler.
// master = the scheduler itself, slave = the surrounding pipeline.
interface issue_scheduler_if;
  import issue_scheduler_pkg::*;

  logic           q_empty;
  decoded_instr_t q_instr;
  logic           q_r_en;
  decoded_instr_t iss_instr;
  logic           alu_valid;
  logic           lsu_valid;
  logic           br_valid;
  logic           alu_ready;
  logic           lsu_ready;
  logic           br_ready;
  logic           wb_valid;
  logic [REG_W-1:0] wb_rd;
  logic           flush;
  logic           stall_hazard;

  modport master (
    input  q_empty, q_instr, alu_ready, lsu_ready, br_ready,
           wb_valid, wb_rd, flush,
    output q_r_en, iss_instr, alu_valid, lsu_valid, br_valid, stall_hazard
  );

  modport slave (
    output q_empty, q_instr, alu_ready, lsu_ready, br_ready,
           wb_valid, wb_rd, flush,
    input  q_r_en, iss_instr, alu_valid, lsu_valid, br_valid, stall_hazard
  );

endinterface

// File: rtl/issue_scheduler_scoreboard.sv
// Busy-register scoreboard: one bit per architectural register, set at issue,
// cleared at writeback; read ports see a same-cycle writeback as already done.
module issue_scheduler_scoreboard
  import issue_scheduler_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             set_en,
  input  logic [REG_W-1:0] set_idx,
  input  logic             clr_en,
  input  logic [REG_W-1:0] clr_idx,
  input  logic [REG_W-1:0] rs1_idx,
  input  logic [REG_W-1:0] rs2_idx,
  input  logic [REG_W-1:0] rd_idx,
  output logic             rs1_busy,
  output logic             rs2_busy,
  output logic             rd_busy
);

  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;
  logic [NUM_REGS-1:0] busy_eff;

  genvar gi;
  for (gi = 0; gi < NUM_REGS; gi++) begin : g_bit
    localparam bit LIVE = (gi != 0);
    logic set_hit;
    logic clr_hit;

    assign set_hit = set_en & (set_idx == REG_W'(gi));
    assign clr_hit = clr_en & (clr_idx == REG_W'(gi));
    // A new producer issuing on the writeback cycle keeps the register busy
    assign busy_d[gi]   = LIVE & (set_hit | (busy_q[gi] & ~clr_hit));
    assign busy_eff[gi] = LIVE & busy_q[gi] & ~clr_hit;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign rs1_busy = busy_eff[rs1_idx];
  assign rs2_busy = busy_eff[rs2_idx];
  assign rd_busy  = busy_eff[rd_idx];

endmodule

// File: rtl/issue_scheduler.sv
// In-order single-issue scheduler with a one-entry issue register and RAW/WAW scoreboard.
// Define ISSUE_PERF_CNT_EN to add saturating issue / hazard-stall / FU-stall counters.
module issue_scheduler
  import issue_scheduler_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  issue_scheduler_if.master bus
`ifdef ISSUE_PERF_CNT_EN
  ,
  output logic [PERF_W-1:0] perf_issued,
  output logic [PERF_W-1:0] perf_hazard_stalls,
  output logic [PERF_W-1:0] perf_fu_stalls
`endif
);

  state_t         state_q;
  state_t         state_d;
  decoded_instr_t instr_q;
  decoded_instr_t instr_d;

  logic held;
  logic fu_ready;
  logic accept;
  logic slot_free;
  logic hazard;
  logic pop;
  logic stall_hazard;
  logic rs1_busy;
  logic rs2_busy;
  logic rd_busy;

  assign held = (state_q == ST_HELD);

  always_comb begin
    fu_ready = 1'b0;
    case (instr_q.fu)
      FU_ALU:  fu_ready = bus.alu_ready;
      FU_LSU:  fu_ready = bus.lsu_ready;
      FU_BR:   fu_ready = bus.br_ready;
      default: fu_ready = 1'b0;
    endcase
  end

  assign bus.alu_valid = held & (instr_q.fu == FU_ALU);
  assign bus.lsu_valid = held & (instr_q.fu == FU_LSU);
  assign bus.br_valid  = held & (instr_q.fu == FU_BR);
  assign bus.iss_instr = instr_q;

  assign accept    = held & fu_ready;
  assign slot_free = ~held | accept;
  assign hazard    = rs1_busy | rs2_busy | (bus.q_instr.rd_we & rd_busy);
  // rst_n gate keeps the pop strobe quiet while the reset is asserted
  assign pop       = rst_n & ~bus.q_empty & slot_free & ~hazard & ~bus.flush;

  assign stall_hazard     = ~bus.q_empty & hazard;
  assign bus.stall_hazard = stall_hazard;
  assign bus.q_r_en       = pop;

  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    case (state_q)
      ST_EMPTY: begin
        if (pop) begin
          state_d = ST_HELD;
          instr_d = bus.q_instr;
        end
      end
      ST_HELD: begin
        if (pop) begin
          instr_d = bus.q_instr;
        end else if (accept) begin
          state_d = ST_EMPTY;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    // Flush drops the held op; the scoreboard keeps its bits for in-flight writebacks
    if (bus.flush) begin
      state_d = ST_EMPTY;
      instr_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
    end
  end

  issue_scheduler_scoreboard u_sb (
    .clk      (clk),
    .rst_n    (rst_n),
    .set_en   (pop & bus.q_instr.rd_we & reg_nonzero(bus.q_instr.rd)),
    .set_idx  (bus.q_instr.rd),
    .clr_en   (bus.wb_valid),
    .clr_idx  (bus.wb_rd),
    .rs1_idx  (bus.q_instr.rs1),
    .rs2_idx  (bus.q_instr.rs2),
    .rd_idx   (bus.q_instr.rd),
    .rs1_busy (rs1_busy),
    .rs2_busy (rs2_busy),
    .rd_busy  (rd_busy)
  );

`ifdef ISSUE_PERF_CNT_EN
  logic [2:0]        perf_inc;
  logic [PERF_W-1:0] perf_q [3];
  logic [PERF_W-1:0] perf_d [3];

  assign perf_inc = {held & ~accept, stall_hazard, accept};

  genvar gi;
  for (gi = 0; gi < 3; gi++) begin : g_perf
    assign perf_d[gi] = (perf_inc[gi] && (perf_q[gi] != '1)) ? perf_q[gi] + 1'b1 : perf_q[gi];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        perf_q[gi] <= '0;
      end else begin
        perf_q[gi] <= perf_d[gi];
      end
    end
  end

  assign perf_issued        = perf_q[0];
  assign perf_hazard_stalls = perf_q[1];
  assign perf_fu_stalls     = perf_q[2];
`endif

endmodule
